// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_entry_t : one buffered fetch result {pc, instr} at the default widths
//   FETCH_PC_INCR : byte distance between consecutive sequential fetches
package fetch_unit_pkg;

  localparam int FU_ADDR_WIDTH  = 32;
  localparam int FU_INSTR_WIDTH = 32;
  localparam int FETCH_PC_INCR  = 4;

  typedef struct packed {
    logic [FU_ADDR_WIDTH-1:0]  pc;
    logic [FU_INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory bus between the fetch unit (master) and instruction memory (slave).
//   req_valid/req_ready/req_addr : in-order fetch requests
//   resp_valid/resp_data         : in-order response words, no back-pressure
interface fetch_unit_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);

  logic                   req_valid;
  logic                   req_ready;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic                   resp_valid;
  logic [INSTR_WIDTH-1:0] resp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  resp_valid,
    input  resp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output resp_valid,
    output resp_data
  );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries with flush.
//   clk, rstn   : clock, asynchronous active-low reset
//   push/push_data, pop : enqueue / dequeue (both allowed in the same cycle)
//   flush       : empties the queue, overriding push and pop
//   head        : entry at the read pointer (all zero out of reset)
//   occupancy, full, empty : fill status
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  input  logic          flush,
  output entry_t        head,
  output logic [CW-1:0] occupancy,
  output logic          full,
  output logic          empty
);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          wr_en;
  logic          rd_en;

  assign full      = (count_reg == CW'(DEPTH));
  assign empty     = (count_reg == '0);
  assign occupancy = count_reg;
  assign head      = mem[rd_ptr_reg];

  // A simultaneous pop frees the slot, so a push into a full queue is legal then.
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;

  // Storage is reset so the head reads as zero before anything is written.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en && !flush) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Power-of-two depth: pointers wrap naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(wr_en) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding decode.
//   clk, rstn          : clock, asynchronous active-low reset
//   redirect_valid/pc  : backend redirect, flushes the queue and drops in-flight responses
//   imem               : instruction memory bus (master side)
//   instr_valid/ready  : handshake toward decode
//   instr_out, pc_out  : head instruction and its PC
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    QUEUE_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  fetch_unit_if.master           imem,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0]  pc_out
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] PC_INCR = ADDR_WIDTH'(FETCH_PC_INCR);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
  logic [ADDR_WIDTH-1:0] resp_pc_reg, resp_pc_next;
  logic                  started_reg;
  logic [CW-1:0]         outstanding_reg, outstanding_next;
  logic [CW-1:0]         drop_cnt_reg, drop_cnt_next;

  logic [CW-1:0]         occupancy;
  logic                  queue_empty;
  logic                  queue_full_unused;
  logic                  redirect_lsb_unused;
  entry_t                head;
  entry_t                push_entry;
  logic                  req_fire;
  logic                  push;
  logic                  pop;
  logic                  credit;
  logic [CW:0]           inflight;
  logic [ADDR_WIDTH-1:0] redirect_target;

  assign redirect_target     = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  // Every queued entry plus every in-flight request holds a slot, so a
  // response can never arrive to a full queue.
  assign inflight = {1'b0, occupancy} + {1'b0, outstanding_reg};
  assign credit   = (inflight < (CW+1)'(QUEUE_DEPTH));

  assign imem.req_valid = started_reg & ~redirect_valid & credit;
  assign imem.req_addr  = pc_reg;
  assign req_fire       = imem.req_valid & imem.req_ready;

  // Responses owed to a pre-redirect stream are swallowed while drop_cnt is non-zero.
  assign push = imem.resp_valid & ~redirect_valid & (drop_cnt_reg == '0);
  assign push_entry.pc    = resp_pc_reg;
  assign push_entry.instr = imem.resp_data;

  assign instr_valid = ~queue_empty & ~redirect_valid;
  assign pop         = instr_valid & instr_ready;
  assign instr_out   = head.instr;
  assign pc_out      = head.pc;

  always_comb begin
    pc_next          = pc_reg;
    resp_pc_next     = resp_pc_reg;
    outstanding_next = outstanding_reg + CW'(req_fire) - CW'(imem.resp_valid);
    drop_cnt_next    = drop_cnt_reg;

    if (redirect_valid) begin
      pc_next       = redirect_target;
      resp_pc_next  = redirect_target;
      // A response arriving in the redirect cycle is discarded right here.
      drop_cnt_next = outstanding_reg - CW'(imem.resp_valid);
    end else begin
      if (req_fire) pc_next = pc_reg + PC_INCR;
      if (push) resp_pc_next = resp_pc_reg + PC_INCR;
      if (imem.resp_valid && drop_cnt_reg != '0) drop_cnt_next = drop_cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_reg          <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      started_reg     <= 1'b0;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
    end else begin
      pc_reg          <= pc_next;
      resp_pc_reg     <= resp_pc_next;
      started_reg     <= 1'b1;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
    end
  end

  fetch_queue #(
    .DEPTH   (QUEUE_DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .occupancy (occupancy),
    .full      (queue_full_unused),
    .empty     (queue_empty)
  );

  // Memory must never answer a request that was not issued.
  resp_needs_outstanding: assert property (@(posedge clk) disable iff (!rstn)
    imem.resp_valid |-> (outstanding_reg != '0));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int          AW     = 32;
  localparam int          IW     = 32;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h80;

  logic        clk = 1'b0;
  logic        rstn;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] pc_out;

  fetch_unit_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) imem ();

  fetch_unit #(
    .INSTR_WIDTH (IW),
    .ADDR_WIDTH  (AW),
    .RESET_PC    (RST_PC),
    .QUEUE_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .pc_out         (pc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  int           compared   = 0;
  int           mismatched = 0;
  int           cyc        = 0;
  int           lat        = 1;
  int           last_due   = 0;
  int           fires      = 0;
  int           valid_cycles = 0;
  pend_t        pend[$];
  fetch_entry_t sb[$];
  logic [31:0]  fired[$];
  logic [31:0]  popped[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, then update the memory model after it.
  task automatic cycle();
    fetch_entry_t e;
    #1;
    if (redirect_valid) begin
      check("redirect_instr_valid", 32'(instr_valid), 32'd0);
      sb.delete();
    end
    if (instr_valid) valid_cycles++;
    if (imem.req_valid && imem.req_ready) begin
      int d;
      fires++;
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pend.push_back('{imem.req_addr, d});
      fired.push_back(imem.req_addr);
      e.pc    = imem.req_addr;
      e.instr = mem_word(imem.req_addr);
      sb.push_back(e);
    end
    if (instr_valid && instr_ready) begin
      popped.push_back(pc_out);
      check("pop_sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("pop_pc", pc_out, e.pc);
        check("pop_instr", instr_out, e.instr);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    imem.resp_valid = 1'b0;
    imem.resp_data  = '0;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      imem.resp_valid = 1'b1;
      imem.resp_data  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    cycle();
    redirect_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 32'(imem.req_valid), 32'd0);
    check({tag, "_req_addr"}, imem.req_addr, RST_PC);
    check({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_instr_out"}, instr_out, 32'd0);
    check({tag, "_pc_out"}, pc_out, 32'd0);
  endtask

  initial begin
    int exp_drop;
    bit found;
    imem.req_ready  = 1'b1;
    imem.resp_valid = 1'b0;
    imem.resp_data  = '0;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rstn = 1'b1;
    #1;
    check("started_gate", 32'(imem.req_valid), 32'd0);

    // 1: free-running sequential fetch
    instr_ready = 1'b1;
    lat = 1;
    fired.delete();
    repeat (5) cycle();
    valid_cycles = 0;
    repeat (15) cycle();
    check("t1_no_gaps", 32'(valid_cycles), 32'd15);
    check("t1_fired_cnt", 32'(fired.size() >= 6), 32'd1);
    if (fired.size() >= 6)
      for (int i = 0; i < 6; i++) check("t1_addr", fired[i], RST_PC + 32'(4 * i));

    // 2: decode stalled, credit limit
    instr_ready = 1'b0;
    do_redirect(32'h400);
    fires = 0;
    repeat (10) cycle();
    check("t2_fires", 32'(fires), 32'd4);
    check("t2_req_valid_low", 32'(imem.req_valid), 32'd0);
    check("t2_occupancy", 32'(dut.occupancy), 32'd4);
    instr_ready = 1'b1;
    popped.delete();
    cycle();
    instr_ready = 1'b0;
    check("t2_popped_pc", popped.size() != 0 ? popped[0] : 32'hDEAD_BEEF, 32'h400);
    fires = 0;
    repeat (6) cycle();
    check("t2_one_refill", 32'(fires), 32'd1);

    // 3: redirect with two requests in flight
    lat = 3;
    instr_ready = 1'b1;
    do_redirect(32'h100);
    fired.delete();
    cycle();
    cycle();
    check("t3_fired_0", fired.size() > 0 ? fired[0] : 32'hDEAD_BEEF, 32'h100);
    check("t3_fired_1", fired.size() > 1 ? fired[1] : 32'hDEAD_BEEF, 32'h104);
    check("t3_outstanding", 32'(pend.size()) + 32'(imem.resp_valid), 32'd2);
    do_redirect(32'h203);
    popped.delete();
    #1;
    check("t3_req_valid", 32'(imem.req_valid), 32'd1);
    check("t3_req_addr", imem.req_addr, 32'h200);
    repeat (10) cycle();
    check("t3_first_pc", popped.size() != 0 ? popped[0] : 32'hDEAD_BEEF, 32'h200);

    // 4: memory back-pressure
    lat = 1;
    imem.req_ready = 1'b0;
    do_redirect(32'h300);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_hold_valid", 32'(imem.req_valid), 32'd1);
      check("t4_hold_addr", imem.req_addr, 32'h300);
      cycle();
    end
    imem.req_ready = 1'b1;
    fired.delete();
    cycle();
    check("t4_accepted", fired.size() != 0 ? fired[0] : 32'hDEAD_BEEF, 32'h300);
    check("t4_next_addr", imem.req_addr, 32'h304);
    repeat (6) cycle();

    // 5: redirect together with a response and a pop
    lat = 2;
    do_redirect(32'h500);
    repeat (8) cycle();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (imem.resp_valid && instr_valid) found = 1'b1;
      else cycle();
    end
    check("t5_found_overlap", 32'(found), 32'd1);
    exp_drop = pend.size() + int'(imem.resp_valid) - 1;
    do_redirect(32'h600);
    #1;
    check("t5_instr_valid_after", 32'(instr_valid), 32'd0);
    check("t5_occupancy", 32'(dut.occupancy), 32'd0);
    check("t5_drop_cnt", 32'(dut.drop_cnt_reg), 32'(exp_drop));
    popped.delete();
    repeat (10) cycle();
    check("t5_first_pc", popped.size() != 0 ? popped[0] : 32'hDEAD_BEEF, 32'h600);

    // 6: asynchronous reset mid-operation, then PC wrap
    lat = 3;
    instr_ready = 1'b0;
    do_redirect(32'h700);
    repeat (6) cycle();
    #2;
    rstn = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    pend.delete();
    sb.delete();
    last_due = 0;
    imem.resp_valid = 1'b0;
    imem.resp_data  = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    #1;
    check("rst_mid_started_gate", 32'(imem.req_valid), 32'd0);
    fired.delete();
    cycle();
    cycle();
    check("rst_mid_first_req", fired.size() != 0 ? fired[0] : 32'hDEAD_BEEF, RST_PC);
    lat = 1;
    instr_ready = 1'b1;
    do_redirect(32'hFFFF_FFFF);
    fired.delete();
    popped.delete();
    repeat (8) cycle();
    check("wrap_req_0", fired.size() > 0 ? fired[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    check("wrap_req_1", fired.size() > 1 ? fired[1] : 32'hDEAD_BEEF, 32'h0);
    check("wrap_pop_0", popped.size() > 0 ? popped[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    check("wrap_pop_1", popped.size() > 1 ? popped[1] : 32'hDEAD_BEEF, 32'h0);

    // Drain: every issued fetch must have been delivered.
    imem.req_ready = 1'b0;
    repeat (10) cycle();
    check("drain_sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
